// File: rtl/writeback_stage.sv
// Writeback stage: arbitrates ALU/load results onto the register-file write port and keeps the
// pending-destination scoreboard. Optional macro WB_BYPASS_EN forwards the write port to rs1/rs2.
module writeback_stage #(
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    NUM_REGS     = 32,
    parameter int                    NUM_REGS_LOG = $clog2(NUM_REGS),
    parameter logic [DATA_WIDTH-1:0] STACK_INIT   = 64'h0,
    parameter int                    STARVE_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [NUM_REGS_LOG-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]   alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [NUM_REGS_LOG-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [NUM_REGS_LOG-1:0] issue_rd,
    input  logic [NUM_REGS_LOG-1:0] rs1,
    input  logic [NUM_REGS_LOG-1:0] rs2,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic                    rs1_fwd_valid,
    output logic                    rs2_fwd_valid,
    output logic [DATA_WIDTH-1:0]   rs1_fwd_data,
    output logic [DATA_WIDTH-1:0]   rs2_fwd_data,
    output logic [NUM_REGS_LOG-1:0] write_reg,
    output logic [DATA_WIDTH-1:0]   write_data
);

    localparam int             SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

    logic [NUM_REGS-1:0]     busy_q, busy_d;
    logic [SW-1:0]           starve_q, starve_d;
    logic [NUM_REGS_LOG-1:0] write_reg_q, write_reg_d;
    logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;

    logic                    alu_grant_s, mem_grant_s, any_grant_s, issue_fire_s;
    logic [NUM_REGS_LOG-1:0] win_rd_s;
    logic [DATA_WIDTH-1:0]   win_data_s;

    // Arbitration: load wins unless the ALU has lost STARVE_LIMIT times in a row.
    always_comb begin
        alu_grant_s = 1'b0;
        mem_grant_s = 1'b0;
        if (alu_valid && ((starve_q == STARVE_MAX) || !mem_valid)) begin
            alu_grant_s = 1'b1;
        end else if (mem_valid) begin
            mem_grant_s = 1'b1;
        end else begin
            alu_grant_s = 1'b0;
            mem_grant_s = 1'b0;
        end
    end

    assign alu_ready    = alu_grant_s;
    assign mem_ready    = mem_grant_s;
    assign any_grant_s  = alu_grant_s | mem_grant_s;
    assign issue_ready  = ~busy_q[issue_rd];
    assign issue_fire_s = issue_valid & issue_ready;

    // Winner mux feeding the write port and the scoreboard clear.
    always_comb begin
        win_rd_s   = '0;
        win_data_s = '0;
        case ({alu_grant_s, mem_grant_s})
            2'b10: begin
                win_rd_s   = alu_rd;
                win_data_s = alu_data;
            end
            2'b01: begin
                win_rd_s   = mem_rd;
                win_data_s = mem_data;
            end
            default: begin
                win_rd_s   = '0;
                win_data_s = '0;
            end
        endcase
    end

    // Next-state: starvation counter, write port, scoreboard (set after clear so set wins).
    always_comb begin
        starve_d     = '0;
        write_reg_d  = '0;
        write_data_d = write_data_q;
        busy_d       = busy_q;
        if (alu_valid && !alu_grant_s) begin
            if (starve_q != STARVE_MAX) begin
                starve_d = starve_q + SW'(1);
            end else begin
                starve_d = starve_q;
            end
        end else begin
            starve_d = '0;
        end
        if (any_grant_s) begin
            write_reg_d       = win_rd_s;
            write_data_d      = win_data_s;
            busy_d[win_rd_s]  = 1'b0;
        end else begin
            write_reg_d  = '0;
            write_data_d = write_data_q;
        end
        if (issue_fire_s) begin
            busy_d[issue_rd] = 1'b1;
        end else begin
            busy_d[issue_rd] = busy_d[issue_rd];
        end
        busy_d[0] = 1'b0;
    end

    // State registers; write_data holds the initial stack pointer throughout reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q       <= '0;
            starve_q     <= '0;
            write_reg_q  <= '0;
            write_data_q <= STACK_INIT;
        end else begin
            busy_q       <= busy_d;
            starve_q     <= starve_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

`ifdef WB_BYPASS_EN
    logic rs1_hit_s, rs2_hit_s;

    // A source matching the register being written this cycle is served from the write port.
    always_comb begin
        rs1_hit_s     = (write_reg_q != '0) && (write_reg_q == rs1);
        rs2_hit_s     = (write_reg_q != '0) && (write_reg_q == rs2);
        rs1_busy      = busy_q[rs1] & ~rs1_hit_s;
        rs2_busy      = busy_q[rs2] & ~rs2_hit_s;
        rs1_fwd_valid = rs1_hit_s;
        rs2_fwd_valid = rs2_hit_s;
        rs1_fwd_data  = rs1_hit_s ? write_data_q : '0;
        rs2_fwd_data  = rs2_hit_s ? write_data_q : '0;
    end
`else
    assign rs1_busy      = busy_q[rs1];
    assign rs2_busy      = busy_q[rs2];
    assign rs1_fwd_valid = 1'b0;
    assign rs2_fwd_valid = 1'b0;
    assign rs1_fwd_data  = '0;
    assign rs2_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reset values, scoreboard, arbitration fairness, x0, async reset.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, issue_valid;
    logic        alu_ready, mem_ready, issue_ready;
    logic [4:0]  alu_rd, mem_rd, issue_rd, rs1, rs2;
    logic [63:0] alu_data, mem_data;
    logic        rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid;
    logic [63:0] rs1_fwd_data, rs2_fwd_data;
    logic [4:0]  write_reg;
    logic [63:0] write_data;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] SP = 64'h8000_0000;

    writeback_stage #(
        .DATA_WIDTH  (64),
        .NUM_REGS    (32),
        .STACK_INIT  (SP),
        .STARVE_LIMIT(3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_rd     (issue_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rs1_fwd_valid(rs1_fwd_valid),
        .rs2_fwd_valid(rs2_fwd_valid),
        .rs1_fwd_data (rs1_fwd_data),
        .rs2_fwd_data (rs2_fwd_data),
        .write_reg    (write_reg),
        .write_data   (write_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] alu_pat;
        reset       = 1'b0;
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        issue_valid = 1'b0;
        alu_rd      = 5'd0;
        mem_rd      = 5'd0;
        issue_rd    = 5'd0;
        rs1         = 5'd0;
        rs2         = 5'd0;
        alu_data    = 64'h0;
        mem_data    = 64'h0;

        // Reset held low for three cycles
        repeat (3) step();
        chk("rst_write_data", write_data, SP);
        chk("rst_write_reg", {59'd0, write_reg}, 64'd0);
        chk("rst_fwd_valid", {62'd0, rs1_fwd_valid, rs2_fwd_valid}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            chk($sformatf("rst_rs1_busy_%0d", i), {63'd0, rs1_busy}, 64'd0);
        end
        reset = 1'b1;
        step();

        // Issue x5, then load result for x5
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        #1;
        chk("issue5_ready", {63'd0, issue_ready}, 64'd1);
        step();
        issue_valid = 1'b0;
        rs1         = 5'd5;
        #1;
        chk("rs1_5_busy", {63'd0, rs1_busy}, 64'd1);
        mem_valid = 1'b1;
        mem_rd    = 5'd5;
        mem_data  = 64'hAB;
        #1;
        chk("mem5_ready", {63'd0, mem_ready}, 64'd1);
        chk("rs1_5_busy_pre_grant", {63'd0, rs1_busy}, 64'd1);
        step();
        mem_valid = 1'b0;
        #1;
        chk("wb5_reg", {59'd0, write_reg}, 64'd5);
        chk("wb5_data", write_data, 64'hAB);
        chk("rs1_5_idle", {63'd0, rs1_busy}, 64'd0);
`ifdef WB_BYPASS_EN
        chk("fwd5_valid", {63'd0, rs1_fwd_valid}, 64'd1);
        chk("fwd5_data", rs1_fwd_data, 64'hAB);
`else
        chk("fwd5_valid", {63'd0, rs1_fwd_valid}, 64'd0);
`endif
        step();
        chk("nogrant_reg", {59'd0, write_reg}, 64'd0);
        chk("nogrant_data_hold", write_data, 64'hAB);

        // Both sources valid for six cycles: mem,mem,mem,alu,mem,mem
        alu_pat   = 6'b001000;
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        alu_data  = 64'h11;
        mem_valid = 1'b1;
        mem_rd    = 5'd2;
        mem_data  = 64'h22;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("arb_alu_ready_%0d", k), {63'd0, alu_ready}, {63'd0, alu_pat[k]});
            chk($sformatf("arb_mem_ready_%0d", k), {63'd0, mem_ready}, {63'd0, ~alu_pat[k]});
            step();
            chk($sformatf("arb_wreg_%0d", k), {59'd0, write_reg}, alu_pat[k] ? 64'd1 : 64'd2);
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        step();
        // ALU alone always wins
        alu_valid = 1'b1;
        #1;
        chk("alu_alone_ready", {63'd0, alu_ready}, 64'd1);
        alu_valid = 1'b0;

        // WAW stall on x7, then same-edge re-issue with the grant
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        step();
        chk("waw7_stall_a", {63'd0, issue_ready}, 64'd0);
        step();
        chk("waw7_stall_b", {63'd0, issue_ready}, 64'd0);
        alu_valid = 1'b1;
        alu_rd    = 5'd7;
        alu_data  = 64'h77;
        #1;
        chk("alu7_ready", {63'd0, alu_ready}, 64'd1);
        chk("waw7_stall_grant", {63'd0, issue_ready}, 64'd0);
        step();
        alu_data = 64'h78;
        #1;
        chk("wb7_reg", {59'd0, write_reg}, 64'd7);
        chk("waw7_released", {63'd0, issue_ready}, 64'd1);
        chk("alu7b_ready", {63'd0, alu_ready}, 64'd1);
        step();
        issue_valid = 1'b0;
        alu_valid   = 1'b0;
        rs1         = 5'd7;
        #1;
        chk("set_wins_busy7", {63'd0, rs1_busy}, 64'd1);
        chk("wb7b_data", write_data, 64'h78);
        mem_valid = 1'b1;
        mem_rd    = 5'd7;
        mem_data  = 64'h79;
        step();
        mem_valid = 1'b0;
        #1;
        chk("busy7_cleared", {63'd0, rs1_busy}, 64'd0);

        // Granted write to x0 and issue to x0
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 64'hFF;
        #1;
        chk("alu0_ready", {63'd0, alu_ready}, 64'd1);
        step();
        alu_valid = 1'b0;
        chk("wb0_reg", {59'd0, write_reg}, 64'd0);
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        #1;
        chk("issue0_ready", {63'd0, issue_ready}, 64'd1);
        step();
        issue_valid = 1'b0;
        rs1         = 5'd0;
        #1;
        chk("busy0_zero", {63'd0, rs1_busy}, 64'd0);

        // Async reset in the middle of a grant
        issue_valid = 1'b1;
        issue_rd    = 5'd11;
        step();
        issue_valid = 1'b0;
        mem_valid   = 1'b1;
        mem_rd      = 5'd9;
        mem_data    = 64'h99;
        step();
        rs1 = 5'd11;
        chk("wb9_reg", {59'd0, write_reg}, 64'd9);
        #1;
        chk("busy11_set", {63'd0, rs1_busy}, 64'd1);
        mem_rd   = 5'd10;
        mem_data = 64'hAA;
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_reg", {59'd0, write_reg}, 64'd0);
        chk("async_rst_data", write_data, SP);
        chk("async_rst_busy11", {63'd0, rs1_busy}, 64'd0);
        step();
        chk("rst_grant_dropped", {59'd0, write_reg}, 64'd0);
        chk("rst_data_held", write_data, SP);
        mem_valid = 1'b0;
        reset     = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
